// File: rtl/truth_table_scanner.sv
// Sweeps every input vector of an attached combinational CUT and streams the
// indices where the selected output matches the requested polarity.
module truth_table_scanner #(
  parameter int N_IN   = 14,
  parameter int OUT_W  = 1,
  parameter int SETTLE = 2,
  parameter int DEPTH  = 8,
  localparam int SEL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [SEL_W-1:0] out_sel,
  output logic [N_IN-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [N_IN-1:0]  m_index,
  output logic             busy,
  output logic             done,
  output logic [N_IN:0]    count
);

  typedef enum logic [2:0] {IDLE, APPLY, SAMPLE, DRAIN, DONE} state_t;

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int PAD_W = 1 << SEL_W;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 2);
  localparam logic [AW:0]   OCC_FULL    = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   OCC_ONE     = (AW + 1)'(1);

  state_t            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic              mode_q, mode_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [N_IN:0]     count_q, count_d;
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       occ_q;
  logic [N_IN-1:0]   mem_q [DEPTH];

  logic [PAD_W-1:0]  out_pad;
  logic              match;
  logic              full, empty, push, pop, advance;

  // Zero-padding lets out_sel index safely even when OUT_W is not a power of two.
  assign out_pad = PAD_W'(dut_out);
  assign match   = out_pad[sel_q] ^ mode_q;

  assign full  = (occ_q == OCC_FULL);
  assign empty = (occ_q == '0);
  assign pop   = m_valid && m_ready;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    mode_d   = mode_q;
    sel_d    = sel_q;
    count_d  = count_q;
    push     = 1'b0;
    advance  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d   = mode;
          sel_d    = out_sel;
          count_d  = '0;
          vec_d    = '0;
          settle_d = '0;
          state_d  = (SETTLE == 1) ? SAMPLE : APPLY;
        end
      end
      APPLY: begin
        if (settle_q == SETTLE_LAST) state_d = SAMPLE;
        else                          settle_d = settle_q + 1'b1;
      end
      SAMPLE: begin
        // A pop in this cycle frees the slot, so a full FIFO can still accept.
        if (match) begin
          if (!full || pop) begin
            push    = 1'b1;
            count_d = count_q + 1'b1;
            advance = 1'b1;
          end
        end else begin
          advance = 1'b1;
        end
        if (advance) begin
          if (vec_q == '1) begin
            state_d = DRAIN;
          end else begin
            vec_d    = vec_q + 1'b1;
            settle_d = '0;
            state_d  = (SETTLE == 1) ? SAMPLE : APPLY;
          end
        end
      end
      DRAIN: begin
        if (empty || (occ_q == OCC_ONE && pop)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      mode_q   <= 1'b0;
      sel_q    <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      mode_q   <= mode_d;
      sel_q    <= sel_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 1'b1;
        2'b01:   occ_q <= occ_q - 1'b1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= vec_q;
  end

  assign dut_in  = vec_q;
  assign m_valid = !empty;
  assign m_index = m_valid ? mem_q[rd_ptr_q] : '0;
  assign busy    = (state_q == APPLY) || (state_q == SAMPLE) || (state_q == DRAIN);
  assign done    = (state_q == DONE);
  assign count   = count_q;

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequential stimulus engine that sweeps every input combination of an attached combinational circuit under test (CUT) and streams out the minterm indices of one selected CUT output.
- Feeds the on-set or off-set minterm list to the Quine-McCluskey minimisation stage.
- Parametrised in input count, output count and settle time.
- The output FIFO applies back-pressure: the sweep stalls instead of dropping minterms.

Parameters:
- N_IN, 14, number of CUT inputs; sweep covers 0 .. 2^N_IN-1.
- OUT_W, 1, number of CUT outputs visible to the scanner.
- SETTLE, 2, cycles each vector is held before the CUT output is sampled; minimum 1.
- DEPTH, 8, minterm FIFO depth, power of two, at least 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- mode  input  1  0 = report on-set (output==1), 1 = report off-set (output==0); latched at start.
- out_sel  input  $clog2(OUT_W) (min 1)  index of the CUT output to monitor; latched at start.
- dut_in  output  N_IN  vector driven to the CUT.
- dut_out  input  OUT_W  CUT response.
- m_valid  output  1  minterm available at FIFO head.
- m_ready  input  1  consumer accepts; transfer happens when m_valid && m_ready.
- m_index  output  N_IN  minterm index at FIFO head.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse when the sweep is complete and the FIFO has drained.
- count  output  N_IN+1  number of minterms matched in the current/last sweep.

Behaviour:
- Reset (async, rst_n=0):
  - FSM returns to IDLE.
  - dut_in, m_index, count, FIFO pointers and occupancy = 0.
  - m_valid, busy, done = 0.
  - Applies at any point, including mid-sweep; FIFO contents are discarded.
- FSM states: IDLE, APPLY, SAMPLE, DRAIN, DONE.
- IDLE:
  - start=1 latches mode/out_sel, clears count, sets vec=0, goes to APPLY.
  - busy rises next cycle.
- APPLY:
  - dut_in = vec.
  - A settle counter runs SETTLE-1 cycles, then the FSM moves to SAMPLE.
  - If SETTLE=1, the FSM goes straight to SAMPLE.
  - The vector is held a total of SETTLE cycles, sample cycle included.
- SAMPLE:
  - match = dut_out[out_sel] XOR mode.
  - match=1 and FIFO not full: push vec, count += 1, advance.
  - match=1 and FIFO full: stay in SAMPLE holding dut_in = vec, re-evaluate each cycle, push when space frees.
  - A pop and a push in the same cycle with the FIFO full are allowed: the pop frees the slot.
  - match=0: advance without pushing.
  - Advance: if vec == 2^N_IN-1, go to DRAIN (no wrap); otherwise vec += 1 and go to APPLY.
- DRAIN: wait until the FIFO is empty (last m_valid && m_ready), then go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0 from this cycle.
  - Return to IDLE; count holds until the next start.
- Throughput: with no stalls, a sweep takes 2^N_IN × SETTLE cycles from the first APPLY cycle to the last SAMPLE.
- FIFO:
  - Show-ahead: m_index is valid whenever m_valid=1.
  - Push and pop in the same cycle with the FIFO non-empty leaves occupancy unchanged.
  - Indices emerge in strictly ascending order.
- count: width N_IN+1, so exactly 2^N_IN (all-match) is representable without overflow.
- start while busy: ignored, no effect on state or latched mode/out_sel.
- start in the same cycle as the DONE pulse: ignored; start is accepted only in IDLE.
- dut_out: treated as combinational from dut_in. The scanner adds no synchroniser.

Test Plan:
- N_IN=4, SETTLE=2, DEPTH=4, OUT_W=1; CUT = in[1]&in[0]; mode=0, m_ready=1; pulse start.
  - Required: m_index stream 3, 7, 11, 15.
  - count=4.
  - done pulses once, 32 cycles after the first APPLY cycle plus drain.
  - busy falls with done.
- Same CUT, mode=1.
  - Required: 12 indices 0,1,2,4,5,6,8,9,10,12,13,14 in order.
  - count=12.
- Back-pressure: CUT = constant 1, DEPTH=4, m_ready=0 until cycle 60, then 1.
  - Required: FIFO holds 0..3 and dut_in stalls at 4 in SAMPLE.
  - After release, all 16 indices arrive in order with none lost or duplicated.
  - count=16 (all-match, no overflow).
- OUT_W=2: dut_out[0]=in[0], dut_out[1]=in[3]; out_sel=1, mode=0.
  - Required: indices 8..15.
  - count=8.
- Protocol abuse and reset:
  - start re-pulsed mid-sweep with mode toggled -> ignored, results match the original mode.
  - rst_n=0 for 1 cycle at vec=6 -> all outputs 0, m_valid=0.
  - A new start after reset sweeps from 0 with count restarting at 0.
- SETTLE=1, N_IN=3, CUT = XOR of all inputs.
  - Required: indices 1, 2, 4, 7.
  - 8 sweep cycles.
  - count=4.
